// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//
// CPU-side load/store initiator in front of a single-port 16-bit memory.
// Each accepted request (byte, halfword or 32-bit word) becomes a short
// sequence of 16-bit memory accesses:
//   - byte/halfword load : one read
//   - word load          : two reads (A, then A+1 modulo MEM_DEPTH)
//   - byte store         : read-modify-write of the containing halfword
//   - halfword store     : one write
//   - word store         : two writes (low half to A, high half to A+1)
// Misaligned halfword/word accesses and size 2'b11 complete immediately
// with resp_error = 1 and never touch memory. Byte order is little-endian.
//
// Ports
//   clock, reset                       rising-edge clock, sync active-high reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_write, req_size, req_signed    request kind: store/load, 00/01/10, sign-extend
//   req_addr [ADDR_WIDTH:0]            byte address
//   req_wdata [31:0]                   store data, right-aligned
//   resp_valid, resp_rdata, resp_error one-cycle completion pulse and its payload
//   MEM_MEMCTRL_from_mem_data [15:0]   memory read data, one cycle after a read
//   MEMCTRL_MEM_to_mem_*               memory strobes, word address, write data
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  input  logic [15:0]           MEM_MEMCTRL_from_mem_data,
  output logic                  MEMCTRL_MEM_to_mem_read_enable,
  output logic                  MEMCTRL_MEM_to_mem_write_enable,
  output logic                  MEMCTRL_MEM_to_mem_mem_enable,
  output logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
  output logic [15:0]           MEMCTRL_MEM_to_mem_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_RD_CAP,
    S_RMW_RD,
    S_RMW_WR,
    S_WR_LO,
    S_WR_HI,
    S_RESP
  } state_e;

  // State and registered outputs
  state_e                state_q,      state_d;
  logic                  ready_q,      ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  rd_en_q,      rd_en_d;
  logic                  wr_en_q,      wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [15:0]           data_q,       data_d;

  // Request fields captured on accept, plus the low half of a word load
  logic [1:0]            size_q,       size_d;
  logic                  signed_q,     signed_d;
  logic                  byte_sel_q,   byte_sel_d;
  logic [15:0]           pend_q,       pend_d;   // word store: high half; byte store: [7:0] = byte
  logic [15:0]           lo_q,         lo_d;

  logic        accept;
  logic        req_err;
  logic [7:0]  rd_byte;
  logic [15:0] rmw_merged;

  assign accept  = req_valid && ready_q;
  assign req_err = (req_size == SZ_ILL) || ((req_size != SZ_BYTE) && req_addr[0]);

  // Byte lane of the halfword currently on the read bus
  assign rd_byte = byte_sel_q ? MEM_MEMCTRL_from_mem_data[15:8]
                              : MEM_MEMCTRL_from_mem_data[7:0];

  // Read data arrives in RMW_WR itself, so the merge has to be combinational
  // to be written back in the same cycle.
  assign rmw_merged = byte_sel_q ? {pend_q[7:0], MEM_MEMCTRL_from_mem_data[7:0]}
                                 : {MEM_MEMCTRL_from_mem_data[15:8], pend_q[7:0]};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    size_d       = size_q;
    signed_d     = signed_q;
    byte_sel_d   = byte_sel_q;
    pend_d       = pend_q;
    lo_d         = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d    = 1'b0;
          size_d     = req_size;
          signed_d   = req_signed;
          byte_sel_d = req_addr[0];
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            addr_d = req_addr[ADDR_WIDTH:1];
            if (!req_write) begin
              state_d = S_RD_LO;
              rd_en_d = 1'b1;
            end else if (req_size == SZ_BYTE) begin
              state_d = S_RMW_RD;
              rd_en_d = 1'b1;
              pend_d  = {8'h00, req_wdata[7:0]};
            end else begin
              state_d = S_WR_LO;
              wr_en_d = 1'b1;
              data_d  = req_wdata[15:0];
              pend_d  = req_wdata[31:16];
            end
          end
        end
      end

      S_RD_LO: begin
        if (size_q == SZ_WORD) begin
          state_d = S_RD_HI;
          rd_en_d = 1'b1;
          addr_d  = addr_q + WORD_STEP;  // wraps modulo MEM_DEPTH
        end else begin
          state_d = S_RD_CAP;
        end
      end

      S_RD_HI: begin
        lo_d    = MEM_MEMCTRL_from_mem_data;
        state_d = S_RD_CAP;
      end

      S_RD_CAP: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        unique case (size_q)
          SZ_BYTE: resp_rdata_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
          SZ_HALF: resp_rdata_d = {{16{signed_q & MEM_MEMCTRL_from_mem_data[15]}},
                                   MEM_MEMCTRL_from_mem_data};
          default: resp_rdata_d = {MEM_MEMCTRL_from_mem_data, lo_q};
        endcase
      end

      S_RMW_RD: begin
        state_d = S_RMW_WR;
        wr_en_d = 1'b1;
      end

      S_RMW_WR: begin
        data_d       = rmw_merged;  // keep the value that was driven
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
      end

      S_WR_LO: begin
        if (size_q == SZ_WORD) begin
          state_d = S_WR_HI;
          wr_en_d = 1'b1;
          addr_d  = addr_q + WORD_STEP;
          data_d  = pend_q;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0;
        end
      end

      S_WR_HI: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
      end

      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments only; every flop has a reset value.
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= 16'h0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      byte_sel_q   <= 1'b0;
      pend_q       <= 16'h0;
      lo_q         <= 16'h0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      byte_sel_q   <= byte_sel_d;
      pend_q       <= pend_d;
      lo_q         <= lo_d;
    end
  end

  // Ready is masked while reset is asserted so no request slips in during
  // the cycle in which the state is being forced back to IDLE.
  assign req_ready  = ready_q & ~reset;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;

  assign MEMCTRL_MEM_to_mem_read_enable  = rd_en_q;
  assign MEMCTRL_MEM_to_mem_write_enable = wr_en_q;
  assign MEMCTRL_MEM_to_mem_mem_enable   = rd_en_q | wr_en_q;
  assign MEMCTRL_MEM_to_mem_address      = addr_q;
  assign MEMCTRL_MEM_to_mem_data         = (state_q == S_RMW_WR) ? rmw_merged : data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. A behavioural 4096 x 16 memory
// with one-cycle read latency sits on the memory bus. Stimulus pushes the
// hand-computed response (data, error, latency) into a scoreboard queue;
// a monitor on the falling edge pops and compares on every resp_valid,
// logs memory writes/reads and watches the enable rules.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int MEM_DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [15:0] mem_rdata;
  logic        mem_re;
  logic        mem_we;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;

  mem_access_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .req_valid                       (req_valid),
    .req_ready                       (req_ready),
    .req_write                       (req_write),
    .req_size                        (req_size),
    .req_signed                      (req_signed),
    .req_addr                        (req_addr),
    .req_wdata                       (req_wdata),
    .resp_valid                      (resp_valid),
    .resp_rdata                      (resp_rdata),
    .resp_error                      (resp_error),
    .MEM_MEMCTRL_from_mem_data       (mem_rdata),
    .MEMCTRL_MEM_to_mem_read_enable  (mem_re),
    .MEMCTRL_MEM_to_mem_write_enable (mem_we),
    .MEMCTRL_MEM_to_mem_mem_enable   (mem_en),
    .MEMCTRL_MEM_to_mem_address      (mem_addr),
    .MEMCTRL_MEM_to_mem_data         (mem_wdata)
  );

  always #5 clock = ~clock;

  // Behavioural memory: synchronous write, read data valid the next cycle
  logic [15:0] mem [MEM_DEPTH];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [27:0] wr_log[$];   // {word address, data} of every write seen
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          rd_cnt = 0;
  int          en_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: bus bookkeeping and scoreboard comparison
  exp_t mon_e;
  always @(negedge clock) begin
    if ((mem_re && mem_we) || (mem_en !== (mem_re | mem_we))) en_viol <= en_viol + 1;
    if (mem_re) rd_cnt <= rd_cnt + 1;
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (req_valid && req_ready) accept_cyc <= cyc + 1;
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp_queue_size", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_rdata", resp_rdata, mon_e.rdata);
        check("resp_error", {31'h0, resp_error}, {31'h0, mon_e.err});
        check("resp_latency", 32'(cyc - accept_cyc + 1), {28'h0, mon_e.lat});
      end
    end
  end

  // Issue one request; inputs change #1 after the rising edge.
  task automatic send_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [12:0] a, input logic [31:0] wd, input logic push,
                          input logic [31:0] erd, input logic eerr, input logic [3:0] elat);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {31'h0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    if (push) sb_q.push_back('{rdata: erd, err: eerr, lat: elat});
    @(posedge clock); #1;
    // Scramble the payload: the DUT must work from what it registered.
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_size   = 2'b11;
    req_signed = ~sg;
    req_addr   = ~a;
    req_wdata  = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("resp_timeout_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [12:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input logic [3:0] elat);
    send_req(wr, sz, sg, a, wd, 1'b1, erd, eerr, elat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected one");
    $fatal(1);
  end

  int w0;
  int r0;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 13'h0;
    req_wdata  = 32'h0;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready",  {31'h0, req_ready},  32'd0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'h0, resp_error}, 32'd0);
    check("rst_enables",    {29'h0, mem_re, mem_we, mem_en}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_address",    {20'h0, mem_addr}, 32'h0);
    check("rst_data",       {16'h0, mem_wdata}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clock); #1;

    // Word store then word load at 0x0010
    w0 = wr_log.size();
    do_req(1'b1, 2'b10, 1'b0, 13'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'd3);
    check("ws_lo_mem", {16'h0, mem[12'h008]}, 32'h0000_BEEF);
    check("ws_hi_mem", {16'h0, mem[12'h009]}, 32'h0000_DEAD);
    check("ws_write_count", 32'(wr_log.size() - w0), 32'd2);
    if (wr_log.size() >= w0 + 2) begin
      check("ws_write0", {4'h0, wr_log[w0]},     {4'h0, 12'h008, 16'hBEEF});
      check("ws_write1", {4'h0, wr_log[w0 + 1]}, {4'h0, 12'h009, 16'hDEAD});
    end
    do_req(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'd4);

    // Error cases: no memory traffic at all
    w0 = wr_log.size();
    r0 = rd_cnt;
    do_req(1'b0, 2'b01, 1'b0, 13'h0003, 32'h0, 32'h0, 1'b1, 4'd1);  // misaligned halfword load
    do_req(1'b0, 2'b11, 1'b0, 13'h0004, 32'h0, 32'h0, 1'b1, 4'd1);  // illegal size load
    do_req(1'b1, 2'b10, 1'b0, 13'h0011, 32'h1111_2222, 32'h0, 1'b1, 4'd1);  // misaligned word store
    do_req(1'b1, 2'b11, 1'b0, 13'h0010, 32'h3333_4444, 32'h0, 1'b1, 4'd1);  // illegal size store
    check("err_no_reads",  32'(rd_cnt - r0), 32'd0);
    check("err_no_writes", 32'(wr_log.size() - w0), 32'd0);
    check("err_mem_untouched", {mem[12'h009], mem[12'h008]}, 32'hDEAD_BEEF);

    // Halfword store 0x80F1 into word 0x004, then sign/zero-extended loads
    do_req(1'b1, 2'b01, 1'b0, 13'h0008, 32'hFFFF_80F1, 32'h0, 1'b0, 4'd2);
    check("hs_mem", {16'h0, mem[12'h004]}, 32'h0000_80F1);
    do_req(1'b0, 2'b00, 1'b1, 13'h0009, 32'h0, 32'hFFFF_FF80, 1'b0, 4'd3);
    do_req(1'b0, 2'b00, 1'b0, 13'h0008, 32'h0, 32'h0000_00F1, 1'b0, 4'd3);
    do_req(1'b0, 2'b00, 1'b1, 13'h0008, 32'h0, 32'hFFFF_FFF1, 1'b0, 4'd3);
    do_req(1'b0, 2'b00, 1'b0, 13'h0009, 32'h0, 32'h0000_0080, 1'b0, 4'd3);
    do_req(1'b0, 2'b01, 1'b1, 13'h0008, 32'h0, 32'hFFFF_80F1, 1'b0, 4'd3);
    do_req(1'b0, 2'b01, 1'b0, 13'h0008, 32'h0, 32'h0000_80F1, 1'b0, 4'd3);

    // Byte store read-modify-write into word 0x004 = 0x1234
    do_req(1'b1, 2'b01, 1'b0, 13'h0008, 32'h0000_1234, 32'h0, 1'b0, 4'd2);
    w0 = wr_log.size();
    r0 = rd_cnt;
    do_req(1'b1, 2'b00, 1'b0, 13'h0009, 32'hFFFF_FF5A, 32'h0, 1'b0, 4'd3);
    check("rmw_read_count",  32'(rd_cnt - r0), 32'd1);
    check("rmw_write_count", 32'(wr_log.size() - w0), 32'd1);
    if (wr_log.size() > w0) check("rmw_write0", {4'h0, wr_log[w0]}, {4'h0, 12'h004, 16'h5A34});
    do_req(1'b0, 2'b01, 1'b0, 13'h0008, 32'h0, 32'h0000_5A34, 1'b0, 4'd3);
    do_req(1'b1, 2'b00, 1'b0, 13'h0008, 32'h1234_56A5, 32'h0, 1'b0, 4'd3);
    check("rmw_lo_mem", {16'h0, mem[12'h004]}, 32'h0000_5AA5);

    // Word store/load across the top of memory
    do_req(1'b1, 2'b10, 1'b0, 13'h1FFE, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd3);
    check("wrap_lo_mem", {16'h0, mem[12'hFFF]}, 32'h0000_F00D);
    check("wrap_hi_mem", {16'h0, mem[12'h000]}, 32'h0000_CAFE);
    do_req(1'b0, 2'b10, 1'b1, 13'h1FFE, 32'h0, 32'hCAFE_F00D, 1'b0, 4'd4);

    // Reset during WR_LO of a word store: low half lands, high half never issued
    do_req(1'b1, 2'b01, 1'b0, 13'h0102, 32'h0000_1111, 32'h0, 1'b0, 4'd2);
    w0 = wr_log.size();
    send_req(1'b1, 2'b10, 1'b0, 13'h0100, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 4'd0);
    reset = 1'b1;            // now in WR_LO
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_req_ready",  {31'h0, req_ready},  32'd1);
    check("midrst_enables",    {29'h0, mem_re, mem_we, mem_en}, 32'd0);
    check("midrst_resp_valid", {31'h0, resp_valid}, 32'd0);
    repeat (6) @(posedge clock);
    #1;
    check("midrst_write_count", 32'(wr_log.size() - w0), 32'd1);
    check("midrst_lo_mem", {16'h0, mem[12'h080]}, 32'h0000_5678);
    check("midrst_hi_mem", {16'h0, mem[12'h081]}, 32'h0000_1111);

    // Still functional after the mid-operation reset
    do_req(1'b0, 2'b10, 1'b0, 13'h0100, 32'h0, 32'h1111_5678, 1'b0, 4'd4);

    check("enable_rules_violations", 32'(en_viol), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
